// File: rtl/seg_scan_mux_if.sv
// rtl/seg_scan_mux_if.sv - digit data load and display drive signals of seg_scan_mux
interface seg_scan_mux_if #(
   parameter int NUM_DIGITS = 4
);
   logic [4*NUM_DIGITS-1:0]       digits_in;
   logic [NUM_DIGITS-1:0]         digit_en_in;
   logic                          load;
   logic [NUM_DIGITS-1:0]         anode;
   logic [3:0]                    nibble_out;
   logic [$clog2(NUM_DIGITS)-1:0] digit_idx;
   logic                          frame_tick;

   modport master (
      output digits_in, digit_en_in, load,
      input  anode, nibble_out, digit_idx, frame_tick
   );

   modport slave (
      input  digits_in, digit_en_in, load,
      output anode, nibble_out, digit_idx, frame_tick
   );
endinterface

// File: rtl/seg_scan_mux.sv
// rtl/seg_scan_mux.sv - N-digit multiplexed display scanner with slot blanking and tear-free frame buffering
module seg_scan_mux #(
   parameter int NUM_DIGITS       = 4,
   parameter int REFRESH_DIV      = 65536,
   parameter int BLANK_CYCLES     = 256,
   parameter bit ANODE_ACTIVE_LOW = 1'b1,
   parameter bit SKIP_DISABLED    = 1'b0
) (
   input logic           clk,
   input logic           reset,
   seg_scan_mux_if.slave bus
);
   localparam int IW = $clog2(NUM_DIGITS);
   localparam int CW = $clog2(REFRESH_DIV);

   typedef enum logic {BLANK, DRIVE} phase_t;

   logic [CW-1:0]           cnt;
   logic [IW-1:0]           idx;
   logic [4*NUM_DIGITS-1:0] pend_dig;
   logic [4*NUM_DIGITS-1:0] act_dig;
   logic [NUM_DIGITS-1:0]   pend_en;
   logic [NUM_DIGITS-1:0]   act_en;
   logic                    frame_tick;

   phase_t                  phase;
   logic                    slot_end;
   logic                    wrap;
   logic                    boundary;
   logic                    up_found;
   logic [IW-1:0]           up_idx;
   logic [IW-1:0]           low_idx;
   logic [IW-1:0]           next_idx;
   logic [NUM_DIGITS-1:0]   next_en;
   logic [NUM_DIGITS-1:0]   anode_on;

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt        <= '0;
         idx        <= '0;
         pend_dig   <= '0;
         pend_en    <= '0;
         act_dig    <= '0;
         act_en     <= '0;
         frame_tick <= 1'b0;
      end else begin
         frame_tick <= boundary;
         if (slot_end) begin
            cnt <= '0;
            idx <= next_idx;
         end else begin
            cnt <= cnt + 1'b1;
         end
         if (bus.load) begin
            pend_dig <= bus.digits_in;
            pend_en  <= bus.digit_en_in;
         end
         // A load coinciding with the boundary bypasses pend so it shows in the new frame.
         if (boundary) begin
            act_dig <= bus.load ? bus.digits_in : pend_dig;
            act_en  <= next_en;
         end
      end
   end

   always_comb begin
      phase    = (int'(cnt) < BLANK_CYCLES) ? BLANK : DRIVE;
      slot_end = (int'(cnt) == REFRESH_DIV - 1);
      next_en  = bus.load ? bus.digit_en_in : pend_en;

      up_found = 1'b0;
      up_idx   = '0;
      low_idx  = '0;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         if (i > int'(idx) && act_en[i]) begin
            up_found = 1'b1;
            up_idx   = IW'(i);
         end
         if (next_en[i]) begin
            low_idx = IW'(i);
         end
      end

      // Wrapping under skip restarts at the lowest digit enabled in the incoming frame.
      if (SKIP_DISABLED && (act_en != '0)) begin
         wrap     = !up_found;
         next_idx = up_found ? up_idx : low_idx;
      end else begin
         wrap     = (int'(idx) == NUM_DIGITS - 1);
         next_idx = wrap ? (SKIP_DISABLED ? low_idx : '0) : idx + 1'b1;
      end
      boundary = slot_end && wrap;

      anode_on = '0;
      if (phase == DRIVE && act_en[idx]) begin
         anode_on[idx] = 1'b1;
      end
   end

   assign bus.anode      = ANODE_ACTIVE_LOW ? ~anode_on : anode_on;
   assign bus.nibble_out = act_dig[4*int'(idx) +: 4];
   assign bus.digit_idx  = idx;
   assign bus.frame_tick = frame_tick;
endmodule

// File: tb/tb_seg_scan_mux.sv
// tb/tb_seg_scan_mux.sv - bench for seg_scan_mux: three configurations against a frame-list model
module tb_seg_scan_mux;
   localparam int N   = 4;
   localparam int DIV = 8;

   logic        clk   = 1'b0;
   logic        reset = 1'b1;
   logic        load  = 1'b0;
   logic [15:0] dig   = '0;
   logic [3:0]  en    = '0;
   int          total = 0;
   int          bad   = 0;
   int          j     = 0;

   always #5 clk = ~clk;

   seg_scan_mux_if #(.NUM_DIGITS(N)) if_a ();
   seg_scan_mux_if #(.NUM_DIGITS(N)) if_b ();
   seg_scan_mux_if #(.NUM_DIGITS(N)) if_c ();

   assign if_a.digits_in = dig;  assign if_a.digit_en_in = en;  assign if_a.load = load;
   assign if_b.digits_in = dig;  assign if_b.digit_en_in = en;  assign if_b.load = load;
   assign if_c.digits_in = dig;  assign if_c.digit_en_in = en;  assign if_c.load = load;

   seg_scan_mux #(.NUM_DIGITS(N), .REFRESH_DIV(DIV), .BLANK_CYCLES(2),
                  .ANODE_ACTIVE_LOW(1'b1), .SKIP_DISABLED(1'b0))
      dut_a (.clk(clk), .reset(reset), .bus(if_a.slave));
   seg_scan_mux #(.NUM_DIGITS(N), .REFRESH_DIV(DIV), .BLANK_CYCLES(2),
                  .ANODE_ACTIVE_LOW(1'b1), .SKIP_DISABLED(1'b1))
      dut_b (.clk(clk), .reset(reset), .bus(if_b.slave));
   seg_scan_mux #(.NUM_DIGITS(N), .REFRESH_DIV(DIV), .BLANK_CYCLES(0),
                  .ANODE_ACTIVE_LOW(1'b0), .SKIP_DISABLED(1'b0))
      dut_c (.clk(clk), .reset(reset), .bus(if_c.slave));

   logic [3:0] o_anode [3];
   logic [3:0] o_nib   [3];
   logic [1:0] o_idx   [3];
   logic       o_tick  [3];
   assign o_anode[0] = if_a.anode;  assign o_nib[0] = if_a.nibble_out;
   assign o_idx[0]   = if_a.digit_idx;  assign o_tick[0] = if_a.frame_tick;
   assign o_anode[1] = if_b.anode;  assign o_nib[1] = if_b.nibble_out;
   assign o_idx[1]   = if_b.digit_idx;  assign o_tick[1] = if_b.frame_tick;
   assign o_anode[2] = if_c.anode;  assign o_nib[2] = if_c.nibble_out;
   assign o_idx[2]   = if_c.digit_idx;  assign o_tick[2] = if_c.frame_tick;

   function automatic int blank_of(input int k);
      return (k == 2) ? 0 : 2;
   endfunction
   function automatic bit low_of(input int k);
      return (k != 2);
   endfunction
   function automatic bit skip_of(input int k);
      return (k == 1);
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h at j=%0d", nm, act, exp, j);
      end
   endtask

   // Model: a frame is a list of digit slots fixed at frame start; position/time walk the list.
   int         m_t    [3];
   int         m_pos  [3];
   int         m_len  [3];
   int         m_list [3][4];
   logic [3:0] m_adig [3][4];
   logic [3:0] m_pdig [3][4];
   logic [3:0] m_aen  [3];
   logic [3:0] m_pen  [3];
   logic       m_tick [3];
   bit         started = 1'b0;

   task automatic build_list(input int k);
      m_len[k] = 0;
      for (int i = 0; i < N; i++) begin
         if (!skip_of(k) || m_aen[k] == 4'b0 || m_aen[k][i]) begin
            m_list[k][m_len[k]] = i;
            m_len[k]++;
         end
      end
   endtask

   always @(posedge clk) begin
      bit bnd;
      for (int k = 0; k < 3; k++) begin
         if (reset) begin
            m_t[k] = 0; m_pos[k] = 0; m_aen[k] = '0; m_pen[k] = '0; m_tick[k] = 1'b0;
            for (int i = 0; i < N; i++) begin
               m_adig[k][i] = '0;
               m_pdig[k][i] = '0;
            end
            build_list(k);
         end else begin
            bnd = (m_t[k] == DIV - 1) && (m_pos[k] == m_len[k] - 1);
            m_tick[k] = 1'b0;
            if (load) begin
               m_pen[k] = en;
               for (int i = 0; i < N; i++) m_pdig[k][i] = dig[4*i +: 4];
            end
            if (m_t[k] == DIV - 1) begin
               m_t[k] = 0;
               m_pos[k]++;
               if (bnd) begin
                  m_aen[k] = m_pen[k];
                  for (int i = 0; i < N; i++) m_adig[k][i] = m_pdig[k][i];
                  build_list(k);
                  m_pos[k]  = 0;
                  m_tick[k] = 1'b1;
               end
            end else begin
               m_t[k]++;
            end
         end
      end
      if (reset) started = 1'b1;
   end

   always @(negedge clk) begin
      int         e_idx;
      logic [3:0] on;
      logic [3:0] e_an;
      if (started) begin
         for (int k = 0; k < 3; k++) begin
            e_idx = m_list[k][m_pos[k]];
            on = '0;
            if (m_t[k] >= blank_of(k) && m_aen[k][e_idx]) on[e_idx] = 1'b1;
            e_an = low_of(k) ? ~on : on;
            check($sformatf("model_anode[%0d]", k), 32'(o_anode[k]), 32'(e_an));
            check($sformatf("model_nibble[%0d]", k), 32'(o_nib[k]), 32'(m_adig[k][e_idx]));
            check($sformatf("model_idx[%0d]", k), 32'(o_idx[k]), 32'(e_idx));
            check($sformatf("model_tick[%0d]", k), 32'(o_tick[k]), 32'(m_tick[k]));
         end
      end
   end

   task automatic go_to(input int target);
      while (j < target) begin
         @(negedge clk);
         j++;
      end
   endtask

   task automatic do_load(input logic [15:0] d, input logic [3:0] e);
      dig  = d;
      en   = e;
      load = 1'b1;
      @(negedge clk);
      j++;
      load = 1'b0;
   endtask

   initial begin
      repeat (2) @(negedge clk);
      j = 0;
      check("rst_anode_a", 32'(if_a.anode), 32'h0000000F);
      check("rst_nib_a",   32'(if_a.nibble_out), 32'h0);
      check("rst_idx_a",   32'(if_a.digit_idx), 32'h0);
      check("rst_tick_a",  32'(if_a.frame_tick), 32'h0);
      check("rst_anode_c", 32'(if_c.anode), 32'h0);
      reset = 1'b0;
      do_load(16'h4321, 4'hF);

      go_to(32);
      check("t1_tick_a",  32'(if_a.frame_tick), 32'h1);
      check("t1_blank_a", 32'(if_a.anode), 32'h0000000F);
      check("t1_nib0_a",  32'(if_a.nibble_out), 32'h1);
      check("t6_an0_c",   32'(if_c.anode), 32'h1);
      go_to(33);
      check("t1_tick_off_a", 32'(if_a.frame_tick), 32'h0);
      go_to(43);
      check("t1_an1_a",  32'(if_a.anode), 32'h0000000D);
      check("t1_nib1_a", 32'(if_a.nibble_out), 32'h2);
      check("t6_an1_c",  32'(if_c.anode), 32'h2);
      go_to(64);
      check("t1_tick2_a", 32'(if_a.frame_tick), 32'h1);

      go_to(81);
      do_load(16'hABCD, 4'hF);
      go_to(92);
      check("t2_old3_nib_a", 32'(if_a.nibble_out), 32'h4);
      check("t2_old3_an_a",  32'(if_a.anode), 32'h00000007);
      go_to(99);
      check("t2_new0_nib_a", 32'(if_a.nibble_out), 32'hD);
      check("t2_new0_an_a",  32'(if_a.anode), 32'h0000000E);
      go_to(125);
      check("t2_new3_nib_a", 32'(if_a.nibble_out), 32'hA);

      go_to(127);
      do_load(16'h9999, 4'hF);
      check("t3_tick_a", 32'(if_a.frame_tick), 32'h1);
      go_to(130);
      check("t3_nib_a", 32'(if_a.nibble_out), 32'h9);
      check("t3_idx_a", 32'(if_a.digit_idx), 32'h0);
      check("t3_an_a",  32'(if_a.anode), 32'h0000000E);

      do_load(16'h5678, 4'b0101);
      go_to(160);
      check("t4_tick_a", 32'(if_a.frame_tick), 32'h1);
      check("t4_tick_b", 32'(if_b.frame_tick), 32'h1);
      go_to(171);
      check("t4_dis_an_a", 32'(if_a.anode), 32'h0000000F);
      check("t4_idx_a",    32'(if_a.digit_idx), 32'h1);
      check("t4_idx_b",    32'(if_b.digit_idx), 32'h2);
      check("t4_an_b",     32'(if_b.anode), 32'h0000000B);
      check("t4_nib_b",    32'(if_b.nibble_out), 32'h6);
      go_to(173);
      check("t4_dis_an2_a", 32'(if_a.anode), 32'h0000000F);
      go_to(176);
      check("t4_tick16_b",  32'(if_b.frame_tick), 32'h1);
      check("t4_notick_a",  32'(if_a.frame_tick), 32'h0);
      check("t4_idx0_b",    32'(if_b.digit_idx), 32'h0);
      go_to(179);
      check("t4_an2_a",  32'(if_a.anode), 32'h0000000B);
      check("t4_nib2_a", 32'(if_a.nibble_out), 32'h6);
      check("t6_an2_c",  32'(if_c.anode), 32'h4);
      go_to(192);
      check("t4_tick32_a", 32'(if_a.frame_tick), 32'h1);

      go_to(213);
      reset = 1'b1;
      @(negedge clk);
      j++;
      reset = 1'b0;
      check("t5_an_a",   32'(if_a.anode), 32'h0000000F);
      check("t5_idx_a",  32'(if_a.digit_idx), 32'h0);
      check("t5_tick_a", 32'(if_a.frame_tick), 32'h0);
      check("t5_nib_a",  32'(if_a.nibble_out), 32'h0);
      check("t5_an_b",   32'(if_b.anode), 32'h0000000F);
      check("t5_an_c",   32'(if_c.anode), 32'h0);
      go_to(249);
      check("t5_dark_a", 32'(if_a.anode), 32'h0000000F);
      go_to(250);
      do_load(16'h1234, 4'hF);
      go_to(281);
      check("t5_relit_an_a",  32'(if_a.anode), 32'h0000000E);
      check("t5_relit_nib_a", 32'(if_a.nibble_out), 32'h4);
      go_to(290);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
